aabb_nearest_hit_scheduler: RTL and testbench

- Downstream controller for the per-box AABB slab tester. It takes one ray and walks a table of NUM_BOXES bounding boxes held in a synchronous box RAM.
- For each box it presents the ray and the box bounds to the tester, pulses its start, and consumes the `valid`/`ray_hit`/`tmin_out` result.
- It reports the nearest hit: lowest entry distance, then lowest index.
- It sits between the ray-generation front end and the primitive/shading stage.

---
 rtl/aabb_nearest_hit_scheduler_pkg.sv | 34 +++
 rtl/aabb_nearest_hit_scheduler_tracker.sv | 54 +++++
 rtl/aabb_nearest_hit_scheduler.sv | 203 ++++++++++++++++++++
 tb/tb_aabb_nearest_hit_scheduler.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aabb_nearest_hit_scheduler_pkg.sv
// Shared types for the AABB nearest-hit scheduler: fixed-point word, ray/box vectors and FSM states.
package aabb_nearest_hit_scheduler_pkg;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned Q_BITS = 12;
    localparam logic [WIDTH-1:0] MAX_16 = WIDTH'(16'h7FFF);

    typedef struct packed {
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
        logic [WIDTH-1:0] z;
    } vec3_t;

    typedef vec3_t ray_origin_t;
    typedef vec3_t ray_direction_t;
    typedef vec3_t box_min_t;
    typedef vec3_t box_max_t;

    typedef struct packed {
        box_min_t min;
        box_max_t max;
    } aabb_box_t;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        ISSUE,
        WAIT,
        UPDATE,
        DONE
    } sched_state_e;

endpackage

// File: rtl/aabb_nearest_hit_scheduler_tracker.sv
// Nearest-hit tracker: keeps the best (lowest signed distance, then lowest index) hit of a scan.
module aabb_nearest_hit_scheduler_tracker
    import aabb_nearest_hit_scheduler_pkg::*;
#(
    parameter int unsigned IDX_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_update,
    input  logic             i_hit,
    input  logic [WIDTH-1:0] i_t,
    input  logic [IDX_W-1:0] i_idx,
    output logic             o_best_hit_c,
    output logic [WIDTH-1:0] o_best_t_c,
    output logic [IDX_W-1:0] o_best_idx_c
);

    logic             r_best_hit;
    logic [WIDTH-1:0] r_best_t;
    logic [IDX_W-1:0] r_best_idx;
    logic             w_better;

    // Strict compare so an equal distance never displaces an earlier index.
    assign w_better = i_hit && ($signed(i_t) < $signed(r_best_t));

    always_comb begin
        o_best_hit_c = r_best_hit;
        o_best_t_c   = r_best_t;
        o_best_idx_c = r_best_idx;
        if (i_clear) begin
            o_best_hit_c = 1'b0;
            o_best_t_c   = MAX_16;
            o_best_idx_c = '0;
        end else if (i_update && w_better) begin
            o_best_hit_c = 1'b1;
            o_best_t_c   = i_t;
            o_best_idx_c = i_idx;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_best_hit <= 1'b0;
            r_best_t   <= MAX_16;
            r_best_idx <= '0;
        end else begin
            r_best_hit <= o_best_hit_c;
            r_best_t   <= o_best_t_c;
            r_best_idx <= o_best_idx_c;
        end
    end

endmodule

// File: rtl/aabb_nearest_hit_scheduler.sv
// Walks the box RAM for one ray, drives the slab tester per box and reports the nearest hit.
module aabb_nearest_hit_scheduler
    import aabb_nearest_hit_scheduler_pkg::*;
#(
    parameter  int unsigned NUM_BOXES = 16,
    parameter  int unsigned TIMEOUT   = 64,
    localparam int unsigned IDX_W     = (NUM_BOXES > 1) ? $clog2(NUM_BOXES) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  ray_origin_t      i_ray_origin,
    input  ray_direction_t   i_ray_direction,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_hit,
    output logic [IDX_W-1:0] o_hit_index,
    output logic [WIDTH-1:0] o_hit_t,
    output logic             o_timeout_err,
    output logic             o_box_rd_en,
    output logic [IDX_W-1:0] o_box_rd_addr,
    input  box_min_t         i_box_rd_min,
    input  box_max_t         i_box_rd_max,
    output logic             o_aabb_start,
    output ray_origin_t      o_aabb_origin,
    output ray_direction_t   o_aabb_direction,
    output box_min_t         o_aabb_min,
    output box_max_t         o_aabb_max,
    input  logic             i_aabb_valid,
    input  logic             i_aabb_hit,
    input  logic [WIDTH-1:0] i_aabb_tmin
);

    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

    sched_state_e     r_state;
    sched_state_e     w_state_nxt;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_nxt;
    logic [TMR_W-1:0] r_timer;
    logic             r_cap_hit;
    logic [WIDTH-1:0] r_cap_t;
    ray_origin_t      r_origin;
    ray_direction_t   r_direction;
    aabb_box_t        r_box;

    logic             r_busy;
    logic             r_done;
    logic             r_hit;
    logic [IDX_W-1:0] r_hit_index;
    logic [WIDTH-1:0] r_hit_t;
    logic             r_timeout_err;
    logic             r_box_rd_en;
    logic [IDX_W-1:0] r_box_rd_addr;
    logic             r_aabb_start;

    logic             w_accept;
    logic             w_wait_exit;
    logic             w_timed_out;
    logic             w_update;
    logic             w_last;
    logic             w_best_hit_c;
    logic [WIDTH-1:0] w_best_t_c;
    logic [IDX_W-1:0] w_best_idx_c;

    assign w_last = (r_idx == IDX_W'(NUM_BOXES - 1));

    // Next-state and per-state control strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_accept    = 1'b0;
        w_wait_exit = 1'b0;
        w_timed_out = 1'b0;
        w_update    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_accept    = 1'b1;
                    w_idx_nxt   = '0;
                    w_state_nxt = FETCH;
                end
            end
            FETCH:  w_state_nxt = LOAD;
            LOAD:   w_state_nxt = ISSUE;
            ISSUE:  w_state_nxt = WAIT;
            // Valid is only honoured here, masking a stale valid from the previous box.
            WAIT: begin
                if (i_aabb_valid) begin
                    w_wait_exit = 1'b1;
                    w_state_nxt = UPDATE;
                end else if (r_timer == TMR_W'(TIMEOUT - 1)) begin
                    w_wait_exit = 1'b1;
                    w_timed_out = 1'b1;
                    w_state_nxt = UPDATE;
                end
            end
            UPDATE: begin
                w_update = 1'b1;
                if (w_last) begin
                    w_state_nxt = DONE;
                end else begin
                    w_idx_nxt   = r_idx + 1'b1;
                    w_state_nxt = FETCH;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from the upcoming state so they line up with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_idx         <= '0;
            r_timer       <= '0;
            r_cap_hit     <= 1'b0;
            r_cap_t       <= '0;
            r_origin      <= '0;
            r_direction   <= '0;
            r_box         <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_hit         <= 1'b0;
            r_hit_index   <= '0;
            r_hit_t       <= '0;
            r_timeout_err <= 1'b0;
            r_box_rd_en   <= 1'b0;
            r_box_rd_addr <= '0;
            r_aabb_start  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_idx        <= w_idx_nxt;
            r_box_rd_en  <= (w_state_nxt == FETCH);
            r_aabb_start <= (w_state_nxt == ISSUE);
            r_busy       <= (w_state_nxt != IDLE) && (w_state_nxt != DONE);
            r_done       <= (w_state_nxt == DONE);
            if (w_accept) begin
                r_origin      <= i_ray_origin;
                r_direction   <= i_ray_direction;
                r_timeout_err <= 1'b0;
                r_hit         <= 1'b0;
                r_hit_index   <= '0;
                r_hit_t       <= '0;
            end
            if (w_state_nxt == FETCH) begin
                r_box_rd_addr <= w_idx_nxt;
            end
            if (r_state == LOAD) begin
                r_box.min <= i_box_rd_min;
                r_box.max <= i_box_rd_max;
            end
            if (r_state == ISSUE) begin
                r_timer <= '0;
            end else if ((r_state == WAIT) && !w_wait_exit) begin
                r_timer <= r_timer + 1'b1;
            end
            if (w_wait_exit) begin
                r_cap_hit <= i_aabb_valid && i_aabb_hit;
                r_cap_t   <= i_aabb_tmin;
            end
            if (w_timed_out) begin
                r_timeout_err <= 1'b1;
            end
            if (w_state_nxt == DONE) begin
                r_hit       <= w_best_hit_c;
                r_hit_index <= w_best_idx_c;
                r_hit_t     <= w_best_hit_c ? w_best_t_c : '0;
            end
        end
    end

    aabb_nearest_hit_scheduler_tracker #(
        .IDX_W (IDX_W)
    ) u_tracker (
        .clk          (clk),
        .reset        (reset),
        .i_clear      (w_accept),
        .i_update     (w_update),
        .i_hit        (r_cap_hit),
        .i_t          (r_cap_t),
        .i_idx        (r_idx),
        .o_best_hit_c (w_best_hit_c),
        .o_best_t_c   (w_best_t_c),
        .o_best_idx_c (w_best_idx_c)
    );

    assign o_busy           = r_busy;
    assign o_done           = r_done;
    assign o_hit            = r_hit;
    assign o_hit_index      = r_hit_index;
    assign o_hit_t          = r_hit_t;
    assign o_timeout_err    = r_timeout_err;
    assign o_box_rd_en      = r_box_rd_en;
    assign o_box_rd_addr    = r_box_rd_addr;
    assign o_aabb_start     = r_aabb_start;
    assign o_aabb_origin    = r_origin;
    assign o_aabb_direction = r_direction;
    assign o_aabb_min       = r_box.min;
    assign o_aabb_max       = r_box.max;

endmodule

// File: tb/tb_aabb_nearest_hit_scheduler.sv
// Bench for aabb_nearest_hit_scheduler: box RAM and scripted tester models, directed and random scans.
module tb_aabb_nearest_hit_scheduler;
    import aabb_nearest_hit_scheduler_pkg::*;

    localparam int NB  = 4;
    localparam int TO  = 64;
    localparam int IW  = 2;

    logic           clk;
    logic           reset;
    logic           i_start;
    vec3_t          i_ray_origin, i_ray_direction;
    logic           o_busy, o_done, o_hit, o_timeout_err, o_box_rd_en, o_aabb_start;
    logic [IW-1:0]  o_hit_index, o_box_rd_addr;
    logic [15:0]    o_hit_t;
    vec3_t          i_box_rd_min, i_box_rd_max;
    vec3_t          o_aabb_origin, o_aabb_direction, o_aabb_min, o_aabb_max;
    logic           i_aabb_valid, i_aabb_hit;
    logic [15:0]    i_aabb_tmin;

    int n_vec = 0;
    int n_err = 0;

    // Tester script per box: latency (0 = never valid), hit flag, distance, hold valid afterwards.
    int          cfg_lat [NB];
    bit          cfg_hit [NB];
    logic [15:0] cfg_t   [NB];
    bit          cfg_hold[NB];
    vec3_t       ram_min [NB];
    vec3_t       ram_max [NB];

    aabb_nearest_hit_scheduler #(
        .NUM_BOXES (NB),
        .TIMEOUT   (TO)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .i_start          (i_start),
        .i_ray_origin     (i_ray_origin),
        .i_ray_direction  (i_ray_direction),
        .o_busy           (o_busy),
        .o_done           (o_done),
        .o_hit            (o_hit),
        .o_hit_index      (o_hit_index),
        .o_hit_t          (o_hit_t),
        .o_timeout_err    (o_timeout_err),
        .o_box_rd_en      (o_box_rd_en),
        .o_box_rd_addr    (o_box_rd_addr),
        .i_box_rd_min     (i_box_rd_min),
        .i_box_rd_max     (i_box_rd_max),
        .o_aabb_start     (o_aabb_start),
        .o_aabb_origin    (o_aabb_origin),
        .o_aabb_direction (o_aabb_direction),
        .o_aabb_min       (o_aabb_min),
        .o_aabb_max       (o_aabb_max),
        .i_aabb_valid     (i_aabb_valid),
        .i_aabb_hit       (i_aabb_hit),
        .i_aabb_tmin      (i_aabb_tmin)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read box RAM, one cycle latency.
    always @(posedge clk) begin
        if (o_box_rd_en) begin
            i_box_rd_min <= ram_min[o_box_rd_addr];
            i_box_rd_max <= ram_max[o_box_rd_addr];
        end
    end

    // Scripted tester: identifies the box by min.x, answers L cycles after the start cycle.
    int t_cnt;
    int t_box;
    bit t_active;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            t_active <= 1'b0;
            t_cnt <= 0;
            t_box <= 0;
            i_aabb_valid <= 1'b0;
            i_aabb_hit <= 1'b0;
            i_aabb_tmin <= '0;
        end else if (o_aabb_start) begin
            t_box <= int'(o_aabb_min.x[IW-1:0]);
            t_cnt <= 1;
            t_active <= (cfg_lat[o_aabb_min.x[IW-1:0]] > 1);
            if (cfg_lat[o_aabb_min.x[IW-1:0]] == 1) begin
                i_aabb_valid <= 1'b1;
                i_aabb_hit <= cfg_hit[o_aabb_min.x[IW-1:0]];
                i_aabb_tmin <= cfg_t[o_aabb_min.x[IW-1:0]];
            end else begin
                i_aabb_valid <= 1'b0;
                i_aabb_hit <= 1'b0;
                i_aabb_tmin <= 16'($urandom);
            end
        end else if (t_active) begin
            t_cnt <= t_cnt + 1;
            if (t_cnt + 1 == cfg_lat[t_box]) begin
                i_aabb_valid <= 1'b1;
                i_aabb_hit <= cfg_hit[t_box];
                i_aabb_tmin <= cfg_t[t_box];
                t_active <= 1'b0;
            end
        end else if (!cfg_hold[t_box]) begin
            i_aabb_valid <= 1'b0;
            i_aabb_hit <= 1'b0;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog expired got running want finished");
        $fatal(1);
    end

    task automatic set_box(input int b, input int lat, input bit h, input logic [15:0] t, input bit hold);
        cfg_lat[b] = lat;
        cfg_hit[b] = h;
        cfg_t[b] = t;
        cfg_hold[b] = hold;
    endtask

    // Reference: scan boxes in order, keep strictly smaller distance, count cycles from the rules.
    task automatic model_eval(output int cyc, output bit h, output int idx, output logic [15:0] t,
                              output bit terr);
        int best;
        best = 32'h7FFF;
        cyc = 1; h = 1'b0; idx = 0; t = '0; terr = 1'b0;
        for (int b = 0; b < NB; b++) begin
            if (cfg_lat[b] == 0) begin
                terr = 1'b1;
                cyc += 4 + TO;
            end else begin
                cyc += 4 + cfg_lat[b];
                if (cfg_hit[b] && int'(cfg_t[b]) < best) begin
                    best = int'(cfg_t[b]);
                    h = 1'b1;
                    idx = b;
                end
            end
        end
        if (h) t = 16'(best);
    endtask

    task automatic do_scan(input bit poke, output int cycles, output bit done_again, output bit busy_ok,
                           output vec3_t org, output vec3_t dir);
        org.x = 16'($urandom); org.y = 16'($urandom); org.z = 16'($urandom);
        dir.x = 16'($urandom); dir.y = 16'($urandom); dir.z = 16'($urandom);
        i_ray_origin = org;
        i_ray_direction = dir;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        i_ray_origin = ~org;
        i_ray_direction = ~dir;
        cycles = 1;
        busy_ok = 1'b1;
        while (o_done !== 1'b1 && cycles < 600) begin
            if (o_busy !== 1'b1) busy_ok = 1'b0;
            i_start = poke && (cycles == 5);
            @(negedge clk);
            cycles++;
        end
        i_start = 1'b0;
        @(negedge clk);
        done_again = o_done;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        i_start = 1'b0;
        i_ray_origin = '0;
        i_ray_direction = '0;
        for (int b = 0; b < NB; b++) begin
            ram_min[b].x = 16'(b);
            ram_min[b].y = 16'($urandom);
            ram_min[b].z = 16'($urandom);
            ram_max[b] = {16'($urandom), 16'($urandom), 16'($urandom)};
            set_box(b, 6, 1'b0, '0, 1'b0);
        end
        repeat (3) @(negedge clk);
        n_vec++;
        if ({o_busy, o_done, o_hit, o_timeout_err, o_box_rd_en, o_aabb_start} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_flags got %b want 000000",
                     {o_busy, o_done, o_hit, o_timeout_err, o_box_rd_en, o_aabb_start});
        end
        n_vec++;
        if ({o_hit_index, o_hit_t, o_box_rd_addr} !== '0) begin
            n_err++;
            $display("FAIL reset_result got idx=%0d t=%h addr=%0d want 0", o_hit_index, o_hit_t, o_box_rd_addr);
        end
        n_vec++;
        if ({o_aabb_origin, o_aabb_direction, o_aabb_min, o_aabb_max} !== '0) begin
            n_err++;
            $display("FAIL reset_regs got org=%h min=%h want 0", o_aabb_origin, o_aabb_min);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_nearest();
        int cyc; bit d2, bok; vec3_t org, dir;
        set_box(0, 6, 1'b1, 16'h3000, 1'b0);
        set_box(1, 6, 1'b1, 16'h1000, 1'b0);
        set_box(2, 6, 1'b1, 16'h2000, 1'b0);
        set_box(3, 6, 1'b0, 16'h0100, 1'b0);
        do_scan(1'b0, cyc, d2, bok, org, dir);
        n_vec++;
        if (cyc != 41) begin n_err++; $display("FAIL nearest_cycles got %0d want 41", cyc); end
        n_vec++;
        if ({o_hit, o_hit_index, o_hit_t, o_timeout_err} !== {1'b1, 2'd1, 16'h1000, 1'b0}) begin
            n_err++;
            $display("FAIL nearest_result got hit=%b idx=%0d t=%h terr=%b want 1 1 1000 0",
                     o_hit, o_hit_index, o_hit_t, o_timeout_err);
        end
        n_vec++;
        if ({d2, bok, o_busy} !== 3'b010) begin
            n_err++;
            $display("FAIL nearest_pulse got done_again=%b busy_ok=%b busy=%b want 0 1 0", d2, bok, o_busy);
        end
        n_vec++;
        if (o_aabb_origin !== org || o_aabb_direction !== dir) begin
            n_err++;
            $display("FAIL ray_latch got %h/%h want %h/%h", o_aabb_origin, o_aabb_direction, org, dir);
        end
    endtask

    task automatic test_timeout();
        int cyc; bit d2, bok; vec3_t org, dir;
        set_box(0, 6, 1'b1, 16'h2000, 1'b0);
        set_box(1, 6, 1'b0, 16'h0010, 1'b0);
        set_box(2, 0, 1'b1, 16'h0001, 1'b0);
        set_box(3, 6, 1'b0, 16'h0000, 1'b0);
        do_scan(1'b0, cyc, d2, bok, org, dir);
        n_vec++;
        if (cyc != 99) begin n_err++; $display("FAIL timeout_cycles got %0d want 99", cyc); end
        n_vec++;
        if ({o_hit, o_hit_index, o_hit_t, o_timeout_err} !== {1'b1, 2'd0, 16'h2000, 1'b1}) begin
            n_err++;
            $display("FAIL timeout_result got hit=%b idx=%0d t=%h terr=%b want 1 0 2000 1",
                     o_hit, o_hit_index, o_hit_t, o_timeout_err);
        end
    endtask

    task automatic test_all_miss();
        int cyc; bit d2, bok; vec3_t org, dir;
        for (int b = 0; b < NB; b++) set_box(b, 6, 1'b0, 16'h0123, 1'b0);
        do_scan(1'b0, cyc, d2, bok, org, dir);
        n_vec++;
        if (cyc != 41) begin n_err++; $display("FAIL miss_cycles got %0d want 41", cyc); end
        n_vec++;
        if ({o_hit, o_hit_index, o_hit_t, o_timeout_err, d2} !== '0) begin
            n_err++;
            $display("FAIL miss_result got hit=%b idx=%0d t=%h terr=%b done_again=%b want all 0",
                     o_hit, o_hit_index, o_hit_t, o_timeout_err, d2);
        end
    endtask

    task automatic test_tie_and_zero();
        int cyc; bit d2, bok; vec3_t org, dir;
        set_box(0, 6, 1'b0, 16'h0000, 1'b0);
        set_box(1, 6, 1'b1, 16'h0800, 1'b0);
        set_box(2, 6, 1'b0, 16'h0000, 1'b0);
        set_box(3, 6, 1'b1, 16'h0800, 1'b0);
        do_scan(1'b0, cyc, d2, bok, org, dir);
        n_vec++;
        if ({o_hit, o_hit_index, o_hit_t} !== {1'b1, 2'd1, 16'h0800}) begin
            n_err++;
            $display("FAIL tie_result got hit=%b idx=%0d t=%h want 1 1 0800", o_hit, o_hit_index, o_hit_t);
        end
        set_box(0, 1, 1'b1, 16'h0800, 1'b0);
        set_box(1, 3, 1'b1, 16'h0800, 1'b0);
        set_box(2, 6, 1'b1, 16'h0000, 1'b0);
        set_box(3, 8, 1'b1, 16'h0000, 1'b0);
        do_scan(1'b0, cyc, d2, bok, org, dir);
        n_vec++;
        if (cyc != 35) begin n_err++; $display("FAIL zero_cycles got %0d want 35", cyc); end
        n_vec++;
        if ({o_hit, o_hit_index, o_hit_t} !== {1'b1, 2'd2, 16'h0000}) begin
            n_err++;
            $display("FAIL zero_result got hit=%b idx=%0d t=%h want 1 2 0000", o_hit, o_hit_index, o_hit_t);
        end
    endtask

    task automatic test_stale_valid();
        int cyc; bit d2, bok; vec3_t org, dir;
        set_box(0, 6, 1'b0, 16'h0000, 1'b1);
        set_box(1, 6, 1'b1, 16'h0400, 1'b0);
        set_box(2, 6, 1'b0, 16'h0000, 1'b0);
        set_box(3, 6, 1'b0, 16'h0000, 1'b0);
        do_scan(1'b0, cyc, d2, bok, org, dir);
        n_vec++;
        if (cyc != 41 || {o_hit, o_hit_index, o_hit_t} !== {1'b1, 2'd1, 16'h0400}) begin
            n_err++;
            $display("FAIL stale_valid got cyc=%0d hit=%b idx=%0d t=%h want 41 1 1 0400",
                     cyc, o_hit, o_hit_index, o_hit_t);
        end
        cfg_hold[0] = 1'b0;
    endtask

    task automatic test_start_while_busy();
        int cyc; bit d2, bok; vec3_t org, dir;
        set_box(0, 6, 1'b1, 16'h3000, 1'b0);
        set_box(1, 6, 1'b1, 16'h1000, 1'b0);
        set_box(2, 6, 1'b1, 16'h2000, 1'b0);
        set_box(3, 6, 1'b0, 16'h0100, 1'b0);
        do_scan(1'b1, cyc, d2, bok, org, dir);
        n_vec++;
        if (cyc != 41 || bok !== 1'b1 || o_hit_index !== 2'd1 || o_aabb_origin !== org) begin
            n_err++;
            $display("FAIL busy_start got cyc=%0d busy_ok=%b idx=%0d want 41 1 1", cyc, bok, o_hit_index);
        end
    endtask

    task automatic test_reset_mid_scan();
        int cyc; bit d2, bok; vec3_t org, dir;
        i_ray_origin = {16'h1111, 16'h2222, 16'h3333};
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (25) @(negedge clk);
        reset = 1'b1;
        #1;
        n_vec++;
        if ({o_busy, o_done, o_hit, o_timeout_err, o_box_rd_en, o_aabb_start, o_hit_index, o_hit_t,
             o_box_rd_addr, o_aabb_origin, o_aabb_min} !== '0) begin
            n_err++;
            $display("FAIL reset_mid got busy=%b addr=%0d org=%h want 0", o_busy, o_box_rd_addr, o_aabb_origin);
        end
        @(negedge clk);
        reset = 1'b0;
        d2 = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (o_done !== 1'b0 || o_busy !== 1'b0) d2 = 1'b1;
        end
        n_vec++;
        if (d2) begin n_err++; $display("FAIL reset_no_done got activity=1 want 0"); end
        do_scan(1'b0, cyc, d2, bok, org, dir);
        n_vec++;
        if (cyc != 41 || {o_hit, o_hit_index, o_hit_t} !== {1'b1, 2'd1, 16'h1000}) begin
            n_err++;
            $display("FAIL reset_rescan got cyc=%0d hit=%b idx=%0d t=%h want 41 1 1 1000",
                     cyc, o_hit, o_hit_index, o_hit_t);
        end
    endtask

    task automatic test_random();
        int cyc, ecyc, eidx; bit d2, bok, eh, eterr; logic [15:0] et; vec3_t org, dir;
        for (int s = 0; s < 25; s++) begin
            for (int b = 0; b < NB; b++) begin
                cfg_lat[b] = ($urandom_range(0, 19) == 0) ? 0 : int'($urandom_range(1, 8));
                cfg_hit[b] = 1'($urandom_range(0, 1));
                cfg_hold[b] = ($urandom_range(0, 3) == 0);
                case ($urandom_range(0, 3))
                    0: cfg_t[b] = 16'h0000;
                    1: cfg_t[b] = 16'h0800;
                    default: cfg_t[b] = 16'($urandom_range(0, 32766));
                endcase
            end
            model_eval(ecyc, eh, eidx, et, eterr);
            do_scan(1'b0, cyc, d2, bok, org, dir);
            n_vec++;
            if (cyc != ecyc) begin n_err++; $display("FAIL rand%0d_cycles got %0d want %0d", s, cyc, ecyc); end
            n_vec++;
            if ({o_hit, o_hit_index, o_hit_t, o_timeout_err} !== {eh, IW'(eidx), et, eterr}) begin
                n_err++;
                $display("FAIL rand%0d_result got hit=%b idx=%0d t=%h terr=%b want %b %0d %h %b",
                         s, o_hit, o_hit_index, o_hit_t, o_timeout_err, eh, eidx, et, eterr);
            end
            n_vec++;
            if (d2 !== 1'b0 || bok !== 1'b1) begin
                n_err++;
                $display("FAIL rand%0d_handshake got done_again=%b busy_ok=%b want 0 1", s, d2, bok);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        for (int b = 0; b < NB; b++) cfg_hold[b] = 1'b0;
    endtask

    initial begin
        test_reset();
        test_nearest();
        test_timeout();
        test_all_miss();
        test_tie_and_zero();
        test_stale_valid();
        test_start_while_busy();
        test_reset_mid_scan();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
